// File: rtl/fads_pkg.sv
// Shared definitions for the FADS sort actuator: FSM state encoding and
// timestamp sizing for the in-flight due queue.
package fads_pkg;

  localparam int FADS_DW = 16;
  localparam int TW = FADS_DW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } fads_state_t;

  typedef struct packed {
    logic [TW-1:0] due;
  } fads_entry_t;

endpackage

// File: rtl/fads_due_fifo.sv
// Small FIFO of due timestamps for droplets in flight; head is combinational
// so the top can compare it against the timestamp in the same cycle.
module fads_due_fifo #(
  parameter int W  = 17,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/red_pitaya_fads_actuator.sv
// Turns sort-trigger rising edges into delayed actuation pulses, with up to
// 2^QAW droplets in flight and saturating sorted/dropped event counters.
//
// state | meaning
// IDLE  | no pulse; a due queue head launches a pulse
// PULSE | gate high, width down-counter running
// DEAD  | enforced idle gap after a pulse, deadtime down-counter running
module red_pitaya_fads_actuator import fads_pkg::*; #(
  parameter int DW  = FADS_DW,
  parameter int QAW = 2,
  parameter int CW  = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          sort_trig_i,
  input  logic          enable_i,
  input  logic          clear_i,
  input  logic [DW-1:0] delay_i,
  input  logic [DW-1:0] width_i,
  input  logic [DW-1:0] deadtime_i,
  output logic          asg_trig_o,
  output logic          sort_gate_o,
  output logic          busy_o,
  output logic [CW-1:0] sort_cnt_o,
  output logic [CW-1:0] drop_cnt_o
);

  localparam int TSW = DW + 1;

  logic           trig_q;
  logic           trig_prev;
  logic [TSW-1:0] ts;
  fads_state_t    state;
  logic [DW-1:0]  cnt;
  logic [DW-1:0]  dead_len;
  logic           asg;
  logic [CW-1:0]  sort_cnt;
  logic [CW-1:0]  drop_cnt;

  logic           edge_evt;
  logic           accept;
  logic           push;
  logic           full_drop;
  logic           head_due;
  logic           launch;
  logic           ovl_drop;
  logic [TSW-1:0] due;
  logic [TSW-1:0] head;
  logic           full;
  logic           empty;
  logic [DW-1:0]  width_eff;
  logic [1:0]     drop_inc;
  logic [CW:0]    drop_sum;

  assign edge_evt  = trig_q & ~trig_prev;
  assign accept    = edge_evt & enable_i;
  assign push      = accept & ~full;
  assign full_drop = accept & full;
  assign due       = ts + TSW'(delay_i) + TSW'(1);
  // The head is judged against the state before this edge, so DEAD exit never launches.
  assign head_due  = enable_i & ~empty & (head == ts);
  assign launch    = head_due & (state == IDLE);
  assign ovl_drop  = head_due & (state != IDLE);
  assign width_eff = (width_i == '0) ? DW'(1) : width_i;

  fads_due_fifo #(.W(TSW), .AW(QAW)) u_fifo (
    .clk   (adc_clk_i),
    .rst_n (adc_rstn_i),
    .flush (~enable_i),
    .push  (push),
    .din   (due),
    .pop   (head_due),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      trig_q    <= 1'b0;
      trig_prev <= 1'b0;
      ts        <= '0;
    end else begin
      trig_q    <= sort_trig_i;
      trig_prev <= trig_q;
      ts        <= ts + TSW'(1);
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      dead_len <= '0;
      asg      <= 1'b0;
    end else begin
      asg <= launch;
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= PULSE;
            cnt      <= width_eff;
            dead_len <= deadtime_i;
          end
        end
        PULSE: begin
          if (cnt == DW'(1)) begin
            if (dead_len == '0) begin
              state <= IDLE;
            end else begin
              state <= DEAD;
              cnt   <= dead_len;
            end
          end else begin
            cnt <= cnt - DW'(1);
          end
        end
        DEAD: begin
          if (cnt == DW'(1)) state <= IDLE;
          else               cnt   <= cnt - DW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A queue-full drop and an overlap drop can land in the same cycle.
  assign drop_inc = {1'b0, full_drop} + {1'b0, ovl_drop};
  assign drop_sum = {1'b0, drop_cnt} + {{(CW-1){1'b0}}, drop_inc};

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sort_cnt <= '0;
      drop_cnt <= '0;
    end else if (clear_i) begin
      sort_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (launch && (sort_cnt != '1)) sort_cnt <= sort_cnt + 1'b1;
      drop_cnt <= drop_sum[CW] ? '1 : drop_sum[CW-1:0];
    end
  end

  assign asg_trig_o  = asg;
  assign sort_gate_o = (state == PULSE);
  assign busy_o      = (state != IDLE) | ~empty;
  assign sort_cnt_o  = sort_cnt;
  assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_red_pitaya_fads_actuator.sv
// Directed bench for the FADS actuator; DW is reduced to 12 so the timestamp
// wrap case fits a short run (TW = 13, wrap at 8192).
module tb_red_pitaya_fads_actuator;

  localparam int DW = 12;
  localparam int CW = 32;
  localparam int TSMOD = 1 << (DW + 1);

  logic          adc_clk_i;
  logic          adc_rstn_i;
  logic          sort_trig_i;
  logic          enable_i;
  logic          clear_i;
  logic [DW-1:0] delay_i;
  logic [DW-1:0] width_i;
  logic [DW-1:0] deadtime_i;
  logic          asg_trig_o;
  logic          sort_gate_o;
  logic          busy_o;
  logic [CW-1:0] sort_cnt_o;
  logic [CW-1:0] drop_cnt_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int gate_total = 0;
  int gate_err = 0;
  logic gate_prev = 1'b0;
  int pulse_cyc[$];
  int pulse_sort[$];

  red_pitaya_fads_actuator #(.DW(DW), .QAW(2), .CW(CW)) dut (
    .adc_clk_i   (adc_clk_i),
    .adc_rstn_i  (adc_rstn_i),
    .sort_trig_i (sort_trig_i),
    .enable_i    (enable_i),
    .clear_i     (clear_i),
    .delay_i     (delay_i),
    .width_i     (width_i),
    .deadtime_i  (deadtime_i),
    .asg_trig_o  (asg_trig_o),
    .sort_gate_o (sort_gate_o),
    .busy_o      (busy_o),
    .sort_cnt_o  (sort_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  initial adc_clk_i = 1'b0;
  always #5 adc_clk_i = ~adc_clk_i;

  always @(posedge adc_clk_i) cyc <= cyc + 1;

  // Pulse log: start cycle, sort count at start, gate length, gate/strobe alignment.
  always @(negedge adc_clk_i) begin
    if (asg_trig_o) begin
      pulse_cyc.push_back(cyc);
      pulse_sort.push_back(int'(sort_cnt_o));
      if (!sort_gate_o || gate_prev) gate_err <= gate_err + 1;
    end
    if (sort_gate_o) gate_total <= gate_total + 1;
    gate_prev <= sort_gate_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge adc_clk_i);
      #1;
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
  endtask

  int k, k2, base, g0, i;

  initial begin
    adc_rstn_i = 1'b0; sort_trig_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
    delay_i = 12'd100; width_i = 12'd20; deadtime_i = 12'd10;
    tick(3);
    adc_rstn_i = 1'b1;
    rst_cyc = cyc;
    check("rst_asg", asg_trig_o, 0);
    check("rst_gate", sort_gate_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sort", sort_cnt_o, 0);
    check("rst_drop", drop_cnt_o, 0);

    // single event: delay 100, width 20, deadtime 10
    tick(5);
    base = pulse_cyc.size(); g0 = gate_total;
    k = cyc + 1; sort_trig_i = 1'b1; tick(5); sort_trig_i = 1'b0;
    check("t1_busy_queued", busy_o, 1);
    tick(150);
    check("t1_npulse", pulse_cyc.size() - base, 1);
    check("t1_start", pulse_cyc[base], k + 102);
    check("t1_sort_at_start", pulse_sort[base], 1);
    check("t1_gate_len", gate_total - g0, 20);
    check("t1_sort", sort_cnt_o, 1);
    check("t1_drop", drop_cnt_o, 0);
    check("t1_busy_idle", busy_o, 0);
    do_clear();
    check("clr_sort", sort_cnt_o, 0);

    // two droplets in flight, 30 cycles apart
    deadtime_i = 12'd5;
    base = pulse_cyc.size();
    k = cyc + 1; sort_trig_i = 1'b1; tick(3); sort_trig_i = 1'b0; tick(27);
    k2 = cyc + 1; sort_trig_i = 1'b1; tick(3); sort_trig_i = 1'b0;
    tick(150);
    check("t2_npulse", pulse_cyc.size() - base, 2);
    check("t2_start0", pulse_cyc[base], k + 102);
    check("t2_start1", pulse_cyc[base+1], k2 + 102);
    check("t2_sort_at_start1", pulse_sort[base+1], 2);
    check("t2_sort", sort_cnt_o, 2);
    check("t2_drop", drop_cnt_o, 0);
    do_clear();

    // overlap: second droplet due while the first pulse is still on
    base = pulse_cyc.size();
    k = cyc + 1; sort_trig_i = 1'b1; tick(3); sort_trig_i = 1'b0; tick(7);
    sort_trig_i = 1'b1; tick(3); sort_trig_i = 1'b0;
    tick(150);
    check("t3_npulse", pulse_cyc.size() - base, 1);
    check("t3_start", pulse_cyc[base], k + 102);
    check("t3_sort", sort_cnt_o, 1);
    check("t3_drop", drop_cnt_o, 1);
    do_clear();

    // queue full: fifth edge dropped immediately
    delay_i = 12'd1000; width_i = 12'd1; deadtime_i = 12'd0;
    base = pulse_cyc.size(); g0 = gate_total;
    k = cyc + 1;
    for (int n = 0; n < 5; n++) begin
      sort_trig_i = 1'b1; tick(1); sort_trig_i = 1'b0; tick(2);
    end
    check("t4_drop_early", drop_cnt_o, 1);
    check("t4_no_pulse_yet", pulse_cyc.size() - base, 0);
    tick(1010);
    check("t4_npulse", pulse_cyc.size() - base, 4);
    for (int n = 0; n < 4; n++) check("t4_start", pulse_cyc[base+n], k + 1002 + 3*n);
    check("t4_gate_len", gate_total - g0, 4);
    check("t4_sort", sort_cnt_o, 4);
    check("t4_drop", drop_cnt_o, 1);
    do_clear();

    // zero delay and zero width
    delay_i = 12'd0; width_i = 12'd0; deadtime_i = 12'd0;
    base = pulse_cyc.size(); g0 = gate_total;
    k = cyc + 1; sort_trig_i = 1'b1; tick(2); sort_trig_i = 1'b0; tick(10);
    check("t5_npulse", pulse_cyc.size() - base, 1);
    check("t5_start", pulse_cyc[base], k + 2);
    check("t5_gate_len", gate_total - g0, 1);
    do_clear();

    // held level gives one pulse
    delay_i = 12'd100; width_i = 12'd20; deadtime_i = 12'd10;
    base = pulse_cyc.size();
    k = cyc + 1; sort_trig_i = 1'b1; tick(500); sort_trig_i = 1'b0; tick(150);
    check("t6_npulse", pulse_cyc.size() - base, 1);
    check("t6_start", pulse_cyc[base], k + 102);
    check("t6_sort", sort_cnt_o, 1);
    do_clear();

    // disable flushes three queued entries; edges while disabled ignored
    delay_i = 12'd1000; width_i = 12'd1; deadtime_i = 12'd0;
    base = pulse_cyc.size();
    for (int n = 0; n < 3; n++) begin
      sort_trig_i = 1'b1; tick(1); sort_trig_i = 1'b0; tick(2);
    end
    check("t7_busy_queued", busy_o, 1);
    enable_i = 1'b0; tick(3);
    check("t7_busy_flushed", busy_o, 0);
    sort_trig_i = 1'b1; tick(2); sort_trig_i = 1'b0; tick(2);
    enable_i = 1'b1;
    tick(1100);
    check("t7_npulse", pulse_cyc.size() - base, 0);
    check("t7_sort", sort_cnt_o, 0);
    check("t7_drop", drop_cnt_o, 0);

    // maximum delay across the timestamp wrap, edge seen at ts = TSMOD-10
    delay_i = 12'd4095; width_i = 12'd5; deadtime_i = 12'd0;
    i = 0;
    while (i < 9000 && ((cyc - rst_cyc) % TSMOD) != TSMOD - 11) begin
      tick(1);
      i++;
    end
    check("t8_align", (cyc - rst_cyc) % TSMOD, TSMOD - 11);
    base = pulse_cyc.size();
    k = cyc + 1; sort_trig_i = 1'b1; tick(2); sort_trig_i = 1'b0;
    tick(4095 + 20);
    check("t8_npulse", pulse_cyc.size() - base, 1);
    check("t8_start", pulse_cyc[base], k + 4097);
    do_clear();

    // asynchronous reset mid-pulse with a second droplet still queued
    delay_i = 12'd10; width_i = 12'd50; deadtime_i = 12'd0;
    k = cyc + 1; sort_trig_i = 1'b1; tick(2); sort_trig_i = 1'b0;
    delay_i = 12'd60; tick(3);
    sort_trig_i = 1'b1; tick(2); sort_trig_i = 1'b0; tick(15);
    check("t9_gate_before", sort_gate_o, 1);
    check("t9_sort_before", sort_cnt_o, 1);
    #2 adc_rstn_i = 1'b0;
    #1;
    check("t9_rst_asg", asg_trig_o, 0);
    check("t9_rst_gate", sort_gate_o, 0);
    check("t9_rst_busy", busy_o, 0);
    check("t9_rst_sort", sort_cnt_o, 0);
    check("t9_rst_drop", drop_cnt_o, 0);
    tick(2);
    adc_rstn_i = 1'b1;
    rst_cyc = cyc;
    base = pulse_cyc.size();
    tick(100);
    check("t9_no_pulse", pulse_cyc.size() - base, 0);
    check("t9_sort_after", sort_cnt_o, 0);
    check("t9_drop_after", drop_cnt_o, 0);

    // clear coinciding with a queue-full drop decision
    delay_i = 12'd1000; width_i = 12'd1; deadtime_i = 12'd0;
    for (int n = 0; n < 4; n++) begin
      sort_trig_i = 1'b1; tick(1); sort_trig_i = 1'b0; tick(2);
    end
    sort_trig_i = 1'b1; tick(1);
    clear_i = 1'b1; sort_trig_i = 1'b0; tick(1);
    clear_i = 1'b0; tick(3);
    check("t10_drop_cleared", drop_cnt_o, 0);
    check("t10_busy", busy_o, 1);
    enable_i = 1'b0; tick(2); enable_i = 1'b1; tick(2);

    check("gate_align", gate_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
